// File: rtl/pma_region_table.sv
// pma_region_table: run-time programmable PMA rule table with pipelined lookup and CSR-style config port.
module pma_region_table #(
    parameter int         NrRules      = 8,
    parameter int         AddrWidth    = 64,
    parameter int         LookupStages = 1,
    parameter logic [2:0] DefaultAttr  = 3'b000,
    parameter int         IdxW         = (NrRules > 1) ? $clog2(NrRules) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_req_i,
    input  logic                 cfg_we_i,
    input  logic [3:0]           cfg_idx_i,
    input  logic [1:0]           cfg_field_i,
    input  logic [AddrWidth-1:0] cfg_wdata_i,
    output logic                 cfg_gnt_o,
    output logic                 cfg_rvalid_o,
    output logic [AddrWidth-1:0] cfg_rdata_o,
    output logic                 cfg_err_o,
    input  logic                 lk_valid_i,
    input  logic [AddrWidth-1:0] lk_addr_i,
    output logic                 lk_valid_o,
    output logic                 lk_hit_o,
    output logic [IdxW-1:0]      lk_idx_o,
    output logic                 lk_cached_o,
    output logic                 lk_nonidem_o,
    output logic                 lk_exec_o
);
    logic [NrRules-1:0][AddrWidth-1:0] base_q, len_q;
    logic [NrRules-1:0][3:0]           attr_q;
    logic [IdxW-1:0]                   sel;
    logic                              idx_ok, err;
    logic [AddrWidth-1:0]              rd_val;
    logic [NrRules-1:0]                m_now, m_s;
    logic [NrRules-1:0][2:0]           a_now, a_s;
    logic                              v_s, hit;
    logic [IdxW-1:0]                   idx;
    logic [2:0]                        attr;

    assign cfg_gnt_o = cfg_req_i;
    assign sel       = cfg_idx_i[IdxW-1:0];
    assign idx_ok    = {1'b0, cfg_idx_i} < 5'(NrRules);
    assign err       = !idx_ok || cfg_field_i == 2'd3 || (cfg_we_i && attr_q[sel][3]);
    assign rd_val    = cfg_field_i == 2'd0 ? base_q[sel] :
                       cfg_field_i == 2'd1 ? len_q[sel] : AddrWidth'(attr_q[sel]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            base_q       <= '0;
            len_q        <= '0;
            attr_q       <= '0;
            cfg_rvalid_o <= 1'b0;
            cfg_err_o    <= 1'b0;
            cfg_rdata_o  <= '0;
        end else begin
            cfg_rvalid_o <= cfg_req_i;
            cfg_err_o    <= cfg_req_i && err;
            cfg_rdata_o  <= (cfg_req_i && !cfg_we_i && !err) ? rd_val : '0;
            if (cfg_req_i && cfg_we_i && !err) begin
                if (cfg_field_i == 2'd0) base_q[sel] <= cfg_wdata_i;
                else if (cfg_field_i == 2'd1) len_q[sel] <= cfg_wdata_i;
                else attr_q[sel] <= cfg_wdata_i[3:0];
            end
        end
    end

    // top bound is computed one bit wider so a region may end exactly at 2^AddrWidth
    always_comb begin
        for (int i = 0; i < NrRules; i++) begin
            m_now[i] = len_q[i] != '0 && lk_addr_i >= base_q[i] &&
                       {1'b0, lk_addr_i} < {1'b0, base_q[i]} + {1'b0, len_q[i]};
            a_now[i] = attr_q[i][2:0];
        end
    end

    generate
        if (LookupStages == 2) begin : g_two
            logic                    v_q;
            logic [NrRules-1:0]      m_q;
            logic [NrRules-1:0][2:0] a_q;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    v_q <= 1'b0;
                    m_q <= '0;
                    a_q <= '0;
                end else begin
                    v_q <= lk_valid_i;
                    if (lk_valid_i) begin
                        m_q <= m_now;
                        a_q <= a_now;
                    end
                end
            end
            assign v_s = v_q;
            assign m_s = m_q;
            assign a_s = a_q;
        end else begin : g_one
            assign v_s = lk_valid_i;
            assign m_s = m_now;
            assign a_s = a_now;
        end
    endgenerate

    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        attr = DefaultAttr;
        for (int i = NrRules - 1; i >= 0; i--) begin
            if (m_s[i]) begin
                hit  = 1'b1;
                idx  = IdxW'(i);
                attr = a_s[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lk_valid_o   <= 1'b0;
            lk_hit_o     <= 1'b0;
            lk_idx_o     <= '0;
            lk_exec_o    <= 1'b0;
            lk_nonidem_o <= 1'b0;
            lk_cached_o  <= 1'b0;
        end else begin
            lk_valid_o <= v_s;
            if (v_s) begin
                lk_hit_o <= hit;
                lk_idx_o <= idx;
                {lk_exec_o, lk_nonidem_o, lk_cached_o} <= attr;
            end
        end
    end
endmodule

// File: tb/tb_pma_region_table.sv
// tb_pma_region_table: directed checks of one-stage and two-stage lookup instances sharing stimulus.
module tb_pma_region_table;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_req = 1'b0, cfg_we = 1'b0;
    logic [3:0]  cfg_idx = '0;
    logic [1:0]  cfg_field = '0;
    logic [63:0] cfg_wdata = '0;
    logic        lk_valid = 1'b0;
    logic [63:0] lk_addr = '0;

    logic        g1, rv1, e1, v1, h1, c1, n1, x1;
    logic [63:0] d1;
    logic [2:0]  i1;
    logic        g2, rv2, e2, v2, h2, c2, n2, x2;
    logic [63:0] d2;
    logic [2:0]  i2;

    int pass_cnt = 0, chk_cnt = 0;
    logic        cfg_v, cfg_e;
    logic [63:0] cfg_d;
    logic [7:0]  r1, r2;
    logic        early2, late1;

    always #5 clk = ~clk;

    pma_region_table #(.NrRules(8), .AddrWidth(64), .LookupStages(1), .DefaultAttr(3'b000)) u1 (
        .clk_i(clk), .rst_i(rst), .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx),
        .cfg_field_i(cfg_field), .cfg_wdata_i(cfg_wdata), .cfg_gnt_o(g1), .cfg_rvalid_o(rv1),
        .cfg_rdata_o(d1), .cfg_err_o(e1), .lk_valid_i(lk_valid), .lk_addr_i(lk_addr),
        .lk_valid_o(v1), .lk_hit_o(h1), .lk_idx_o(i1), .lk_cached_o(c1), .lk_nonidem_o(n1), .lk_exec_o(x1));

    pma_region_table #(.NrRules(8), .AddrWidth(64), .LookupStages(2), .DefaultAttr(3'b000)) u2 (
        .clk_i(clk), .rst_i(rst), .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx),
        .cfg_field_i(cfg_field), .cfg_wdata_i(cfg_wdata), .cfg_gnt_o(g2), .cfg_rvalid_o(rv2),
        .cfg_rdata_o(d2), .cfg_err_o(e2), .lk_valid_i(lk_valid), .lk_addr_i(lk_addr),
        .lk_valid_o(v2), .lk_hit_o(h2), .lk_idx_o(i2), .lk_cached_o(c2), .lk_nonidem_o(n2), .lk_exec_o(x2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic we, input logic [3:0] idx, input logic [1:0] field, input logic [63:0] wd);
        cfg_req = 1'b1; cfg_we = we; cfg_idx = idx; cfg_field = field; cfg_wdata = wd;
        step();
        cfg_req = 1'b0; cfg_we = 1'b0;
        cfg_v = rv1; cfg_e = e1; cfg_d = d1;
    endtask

    task automatic do_lookup(input logic [63:0] addr);
        lk_valid = 1'b1; lk_addr = addr;
        step();
        lk_valid = 1'b0;
        r1 = {v1, h1, i1, x1, n1, c1};
        early2 = v2;
        step();
        r2 = {v2, h2, i2, x2, n2, c2};
        late1 = v1;
    endtask

    task automatic test_reset();
        step(); step();
        chk_cnt++; if ({v1, v2, rv1, rv2, e1, d1} !== '0) $display("FAIL reset_outputs got %b", {v1, v2, rv1, rv2, e1}); else pass_cnt++;
        rst = 1'b0;
        do_cfg(1'b0, 4'd0, 2'd2, '0);
        chk_cnt++; if ({cfg_v, cfg_e, cfg_d} !== {2'b10, 64'h0}) $display("FAIL reset_attr_read got %b/%b/%h exp 1/0/0", cfg_v, cfg_e, cfg_d); else pass_cnt++;
        do_lookup(64'h8000_0000);
        chk_cnt++; if (r1 !== 8'b1_0_000_000) $display("FAIL reset_lookup_s1 got %b exp 10000000", r1); else pass_cnt++;
        chk_cnt++; if ({early2, late1} !== 2'b00) $display("FAIL latency got early2=%b late1=%b exp 0 0", early2, late1); else pass_cnt++;
        chk_cnt++; if (r2 !== 8'b1_0_000_000) $display("FAIL reset_lookup_s2 got %b exp 10000000", r2); else pass_cnt++;
    endtask

    task automatic test_basic();
        do_cfg(1'b1, 4'd2, 2'd0, 64'h8000_0000);
        do_cfg(1'b1, 4'd2, 2'd1, 64'h4000_0000);
        do_cfg(1'b1, 4'd2, 2'd2, 64'h1);
        chk_cnt++; if ({cfg_v, cfg_e, g1} !== 3'b100) $display("FAIL basic_write got v=%b err=%b exp 1 0", cfg_v, cfg_e); else pass_cnt++;
        do_lookup(64'h8000_0000);
        chk_cnt++; if ({r1, r2} !== {2{8'b1_1_010_001}}) $display("FAIL basic_low got %b %b exp 11010001", r1, r2); else pass_cnt++;
        do_lookup(64'hBFFF_FFFF);
        chk_cnt++; if ({r1, r2} !== {2{8'b1_1_010_001}}) $display("FAIL basic_top got %b %b exp 11010001", r1, r2); else pass_cnt++;
        do_lookup(64'hC000_0000);
        chk_cnt++; if ({r1, r2} !== {2{8'b1_0_000_000}}) $display("FAIL basic_past got %b %b exp 10000000", r1, r2); else pass_cnt++;
    endtask

    task automatic test_priority();
        do_cfg(1'b1, 4'd1, 2'd0, 64'h1_0000);
        do_cfg(1'b1, 4'd1, 2'd1, 64'h1_0000);
        do_cfg(1'b1, 4'd1, 2'd2, 64'h4);
        do_cfg(1'b1, 4'd3, 2'd0, 64'h1_0000);
        do_cfg(1'b1, 4'd3, 2'd1, 64'h1_0000);
        do_cfg(1'b1, 4'd3, 2'd2, 64'h3);
        do_lookup(64'h1_8000);
        chk_cnt++; if ({r1, r2} !== {2{8'b1_1_001_100}}) $display("FAIL priority got %b %b exp 11001100", r1, r2); else pass_cnt++;
    endtask

    task automatic test_lock();
        do_cfg(1'b1, 4'd4, 2'd2, 64'hC);
        chk_cnt++; if (cfg_e !== 1'b0) $display("FAIL lock_set got err=%b exp 0", cfg_e); else pass_cnt++;
        do_cfg(1'b1, 4'd4, 2'd0, 64'h1000);
        chk_cnt++; if ({cfg_v, cfg_e, cfg_d} !== {2'b11, 64'h0}) $display("FAIL lock_write got %b/%b/%h exp 1/1/0", cfg_v, cfg_e, cfg_d); else pass_cnt++;
        do_cfg(1'b0, 4'd4, 2'd0, '0);
        chk_cnt++; if ({cfg_e, cfg_d} !== {1'b0, 64'h0}) $display("FAIL lock_base got %b/%h exp 0/0", cfg_e, cfg_d); else pass_cnt++;
        do_cfg(1'b0, 4'd4, 2'd2, '0);
        chk_cnt++; if ({cfg_e, cfg_d} !== {1'b0, 64'hC}) $display("FAIL lock_attr got %b/%h exp 0/c", cfg_e, cfg_d); else pass_cnt++;
        rst = 1'b1; step(); rst = 1'b0;
        do_cfg(1'b0, 4'd4, 2'd2, '0);
        chk_cnt++; if (cfg_d !== 64'h0) $display("FAIL lock_cleared got %h exp 0", cfg_d); else pass_cnt++;
        do_cfg(1'b1, 4'd4, 2'd0, 64'h1000);
        chk_cnt++; if (cfg_e !== 1'b0) $display("FAIL unlock_write got err=%b exp 0", cfg_e); else pass_cnt++;
        do_cfg(1'b0, 4'd4, 2'd0, '0);
        chk_cnt++; if (cfg_d !== 64'h1000) $display("FAIL unlock_readback got %h exp 1000", cfg_d); else pass_cnt++;
    endtask

    task automatic test_edges();
        do_cfg(1'b1, 4'd0, 2'd0, 64'hFFFF_FFFF_FFFF_F000);
        do_cfg(1'b1, 4'd0, 2'd1, 64'h1000);
        do_cfg(1'b1, 4'd0, 2'd2, 64'h1);
        do_lookup(64'hFFFF_FFFF_FFFF_FFFF);
        chk_cnt++; if ({r1, r2} !== {2{8'b1_1_000_001}}) $display("FAIL top_region got %b %b exp 11000001", r1, r2); else pass_cnt++;
        do_lookup(64'hFFFF_FFFF_FFFF_EFFF);
        chk_cnt++; if ({r1, r2} !== {2{8'b1_0_000_000}}) $display("FAIL below_top got %b %b exp 10000000", r1, r2); else pass_cnt++;
        do_cfg(1'b0, 4'd9, 2'd0, '0);
        chk_cnt++; if ({cfg_v, cfg_e, cfg_d} !== {2'b11, 64'h0}) $display("FAIL bad_idx got %b/%b/%h exp 1/1/0", cfg_v, cfg_e, cfg_d); else pass_cnt++;
        do_cfg(1'b0, 4'd0, 2'd3, '0);
        chk_cnt++; if ({cfg_e, cfg_d} !== {1'b1, 64'h0}) $display("FAIL bad_field got %b/%h exp 1/0", cfg_e, cfg_d); else pass_cnt++;
        do_cfg(1'b1, 4'd6, 2'd0, 64'h2000);
        do_cfg(1'b1, 4'd6, 2'd2, 64'h7);
        do_lookup(64'h2000);
        chk_cnt++; if ({r1, r2} !== {2{8'b1_0_000_000}}) $display("FAIL zero_len got %b %b exp 10000000", r1, r2); else pass_cnt++;
    endtask

    task automatic test_concurrent();
        logic [7:0] old1, new1, old2;
        do_cfg(1'b1, 4'd5, 2'd0, 64'h5000);
        do_cfg(1'b1, 4'd5, 2'd1, 64'h100);
        do_cfg(1'b1, 4'd5, 2'd2, 64'h1);
        cfg_req = 1'b1; cfg_we = 1'b1; cfg_idx = 4'd5; cfg_field = 2'd2; cfg_wdata = 64'h4;
        lk_valid = 1'b1; lk_addr = 64'h5010;
        step();
        cfg_req = 1'b0; cfg_we = 1'b0;
        old1 = {v1, h1, i1, x1, n1, c1};
        step();
        lk_valid = 1'b0;
        new1 = {v1, h1, i1, x1, n1, c1};
        old2 = {v2, h2, i2, x2, n2, c2};
        step();
        r2 = {v2, h2, i2, x2, n2, c2};
        chk_cnt++; if ({old1, old2} !== {2{8'b1_1_101_001}}) $display("FAIL same_cycle_old got %b %b exp 11101001", old1, old2); else pass_cnt++;
        chk_cnt++; if ({new1, r2} !== {2{8'b1_1_101_100}}) $display("FAIL next_cycle_new got %b %b exp 11101100", new1, r2); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [11:0] vv1, vv2, hv1, hv2;
        vv1 = '0; vv2 = '0; hv1 = '0; hv2 = '0;
        for (int k = 0; k < 12; k++) begin
            lk_valid = k < 10;
            lk_addr  = k[0] ? 64'h9000 : 64'h5000;
            step();
            vv1[k] = v1; vv2[k] = v2; hv1[k] = v1 & h1; hv2[k] = v2 & h2;
        end
        lk_valid = 1'b0;
        chk_cnt++; if (vv1 !== 12'h3FF) $display("FAIL b2b_valid_s1 got %h exp 3ff", vv1); else pass_cnt++;
        chk_cnt++; if (vv2 !== 12'h7FE) $display("FAIL b2b_valid_s2 got %h exp 7fe", vv2); else pass_cnt++;
        chk_cnt++; if (hv1 !== 12'h155) $display("FAIL b2b_hit_s1 got %h exp 155", hv1); else pass_cnt++;
        chk_cnt++; if (hv2 !== 12'h2AA) $display("FAIL b2b_hit_s2 got %h exp 2aa", hv2); else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        lk_valid = 1'b1; lk_addr = 64'h5000;
        step();
        lk_valid = 1'b1; cfg_req = 1'b1; cfg_idx = 4'd5; cfg_field = 2'd0; rst = 1'b1;
        step();
        lk_valid = 1'b0; cfg_req = 1'b0; rst = 1'b0;
        chk_cnt++; if ({v1, v2, rv1, rv2} !== 4'b0000) $display("FAIL midflight_drop got %b exp 0000", {v1, v2, rv1, rv2}); else pass_cnt++;
        step();
        chk_cnt++; if ({v1, v2, rv1, rv2} !== 4'b0000) $display("FAIL midflight_after got %b exp 0000", {v1, v2, rv1, rv2}); else pass_cnt++;
        do_cfg(1'b0, 4'd5, 2'd0, '0);
        chk_cnt++; if (cfg_d !== 64'h0) $display("FAIL midflight_table got %h exp 0", cfg_d); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_lock();
        test_edges();
        test_concurrent();
        test_back_to_back();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
